// File: rtl/muldiv_dispatch_pkg.sv
// rtl/muldiv_dispatch_pkg.sv - RV32M dispatch constants, FSM encoding and funct3 op mapping
package muldiv_dispatch_pkg;

  localparam int MUL_OP_WIDTH = 2;
  localparam int DIV_OP_WIDTH = 2;

  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MUL    = 2'd0;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULH   = 2'd1;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULHSU = 2'd2;
  localparam logic [MUL_OP_WIDTH-1:0] MUL_OP_MULHU  = 2'd3;

  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

  localparam logic [2:0] MDU_F3_MUL    = 3'b000;
  localparam logic [2:0] MDU_F3_MULH   = 3'b001;
  localparam logic [2:0] MDU_F3_MULHSU = 3'b010;
  localparam logic [2:0] MDU_F3_MULHU  = 3'b011;
  localparam logic [2:0] MDU_F3_DIV    = 3'b100;
  localparam logic [2:0] MDU_F3_DIVU   = 3'b101;
  localparam logic [2:0] MDU_F3_REM    = 3'b110;
  localparam logic [2:0] MDU_F3_REMU   = 3'b111;

  typedef enum logic [4:0] {
    S_IDLE     = 5'b00001,
    S_MUL_WAIT = 5'b00010,
    S_DIV_WAIT = 5'b00100,
    S_RELEASE  = 5'b01000,
    S_DONE     = 5'b10000
  } state_t;

  function automatic logic [MUL_OP_WIDTH-1:0] f3_to_mulop(input logic [2:0] f3);
    case (f3)
      MDU_F3_MULH:   return MUL_OP_MULH;
      MDU_F3_MULHSU: return MUL_OP_MULHSU;
      MDU_F3_MULHU:  return MUL_OP_MULHU;
      default:       return MUL_OP_MUL;
    endcase
  endfunction

  function automatic logic [DIV_OP_WIDTH-1:0] f3_to_divop(input logic [2:0] f3);
    case (f3)
      MDU_F3_DIVU: return DIV_OP_DIVU;
      MDU_F3_REM:  return DIV_OP_REM;
      MDU_F3_REMU: return DIV_OP_REMU;
      default:     return DIV_OP_DIV;
    endcase
  endfunction

endpackage

// File: rtl/div_special_case.sv
// rtl/div_special_case.sv - RISC-V divide-by-zero and signed-overflow results, resolved without the divider
module div_special_case
  import muldiv_dispatch_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic is_div_op;
  logic is_rem;
  logic div_zero;
  logic overflow;

  always_comb begin
    is_div_op = funct3[2];
    is_rem    = (funct3 == MDU_F3_REM) || (funct3 == MDU_F3_REMU);
    div_zero  = is_div_op && (op_b == 32'h0);
    overflow  = ((funct3 == MDU_F3_DIV) || (funct3 == MDU_F3_REM)) &&
                (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    is_special     = div_zero || overflow;
    special_result = 32'h0;
    // Divide by zero takes priority; the overflow pair has a non-zero divisor anyway.
    if (div_zero) begin
      special_result = is_rem ? op_a : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_result = is_rem ? 32'h0 : 32'h8000_0000;
    end
  end

endmodule

// File: rtl/muldiv_dispatch.sv
// rtl/muldiv_dispatch.sv - RV32M front-end: decodes funct3, launches multiplier/divider, bypasses specials and repeats
module muldiv_dispatch
  import muldiv_dispatch_pkg::*;
#(
  parameter bit ENABLE_CACHE = 1'b1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [2:0]              funct3,
  input  logic [31:0]             op_a,
  input  logic [31:0]             op_b,
  output logic [31:0]             result,
  output logic                    mul_valid,
  input  logic                    mul_ready,
  output logic [MUL_OP_WIDTH-1:0] MULop,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  input  logic [31:0]             mul_result,
  output logic                    div_valid,
  input  logic                    div_ready,
  output logic [DIV_OP_WIDTH-1:0] DIVop,
  output logic [31:0]             div_a,
  output logic [31:0]             div_b,
  input  logic [31:0]             div_result
);

  state_t state_q;
  state_t state_d;

  logic [2:0]  key_f3_q;
  logic [31:0] key_a_q;
  logic [31:0] key_b_q;

  logic        cache_vld_q;
  logic [2:0]  cache_f3_q;
  logic [31:0] cache_a_q;
  logic [31:0] cache_b_q;
  logic [31:0] cache_val_q;

  logic        is_special;
  logic [31:0] special_result;
  logic        cache_hit;
  logic        is_mul;
  logic        accept;

  div_special_case u_special (
    .funct3         (funct3),
    .op_a           (op_a),
    .op_b           (op_b),
    .is_special     (is_special),
    .special_result (special_result)
  );

  assign cache_hit = ENABLE_CACHE && cache_vld_q && (funct3 == cache_f3_q) &&
                     (op_a == cache_a_q) && (op_b == cache_b_q);
  assign is_mul    = !funct3[2];
  assign accept    = (state_q == S_IDLE) && valid_i;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (cache_hit || is_special) state_d = S_DONE;
          else if (is_mul)             state_d = S_MUL_WAIT;
          else                         state_d = S_DIV_WAIT;
        end
      end
      S_MUL_WAIT: if (mul_ready) state_d = S_RELEASE;
      S_DIV_WAIT: if (div_ready) state_d = S_RELEASE;
      // The unit must drop its ready before the next launch can be trusted.
      S_RELEASE:  if (!mul_ready && !div_ready) state_d = S_DONE;
      S_DONE:     if (!valid_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mul_valid = (state_q == S_MUL_WAIT);
    div_valid = (state_q == S_DIV_WAIT);
    ready_o   = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result      <= 32'h0;
      MULop       <= '0;
      mul_a       <= 32'h0;
      mul_b       <= 32'h0;
      DIVop       <= '0;
      div_a       <= 32'h0;
      div_b       <= 32'h0;
      key_f3_q    <= 3'h0;
      key_a_q     <= 32'h0;
      key_b_q     <= 32'h0;
      cache_vld_q <= 1'b0;
      cache_f3_q  <= 3'h0;
      cache_a_q   <= 32'h0;
      cache_b_q   <= 32'h0;
      cache_val_q <= 32'h0;
    end else begin
      if (accept) begin
        key_f3_q <= funct3;
        key_a_q  <= op_a;
        key_b_q  <= op_b;
        if (cache_hit) begin
          result <= cache_val_q;
        end else if (is_special) begin
          result <= special_result;
        end else if (is_mul) begin
          MULop <= f3_to_mulop(funct3);
          mul_a <= op_a;
          mul_b <= op_b;
        end else begin
          DIVop <= f3_to_divop(funct3);
          div_a <= op_a;
          div_b <= op_b;
        end
      end
      // Unit results land in the cache first so result only moves on DONE entry.
      if ((state_q == S_MUL_WAIT && mul_ready) || (state_q == S_DIV_WAIT && div_ready)) begin
        cache_val_q <= (state_q == S_MUL_WAIT) ? mul_result : div_result;
        cache_f3_q  <= key_f3_q;
        cache_a_q   <= key_a_q;
        cache_b_q   <= key_b_q;
        cache_vld_q <= 1'b1;
      end
      if (state_q == S_RELEASE && state_d == S_DONE) begin
        result <= cache_val_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_dispatch.sv
// tb/tb_muldiv_dispatch.sv - randomized self-checking bench for muldiv_dispatch with modelled mul/div units
module tb_muldiv_dispatch;
  import muldiv_dispatch_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic valid_i = 1'b0;
  logic [2:0] funct3 = 3'h0;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic ready_o;
  logic [31:0] result;
  logic mul_valid;
  logic mul_ready;
  logic [MUL_OP_WIDTH-1:0] MULop;
  logic [31:0] mul_a, mul_b, mul_result;
  logic div_valid;
  logic div_ready;
  logic [DIV_OP_WIDTH-1:0] DIVop;
  logic [31:0] div_a, div_b, div_result;

  int n_checks = 0;
  int n_pass = 0;
  int mul_lat = 0, mul_hold = 0, div_lat = 0, div_hold = 0;
  int mul_cnt, mul_hcnt, div_cnt, div_hcnt;
  int mul_launches = 0, div_launches = 0, both_cnt = 0;
  logic mul_prev = 1'b0, div_prev = 1'b0;

  logic ref_vld = 1'b0;
  logic [2:0] ref_f3 = 3'h0;
  logic [31:0] ref_a = 32'h0, ref_b = 32'h0;
  logic [31:0] pool [6] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7, 32'hFFFF_FFFE};

  muldiv_dispatch #(.ENABLE_CACHE(1'b1)) dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i), .ready_o(ready_o),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .result(result),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .MULop(MULop),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_valid(div_valid), .div_ready(div_ready), .DIVop(DIVop),
    .div_a(div_a), .div_b(div_b), .div_result(div_result)
  );

  always #5 clk = ~clk;

  // RV32M semantics straight from the ISA rules.
  function automatic logic [31:0] rv32m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // 0 cache hit, 1 special case, 2 multiplier, 3 divider
  function automatic int predict(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (ref_vld && ref_f3 == f3 && ref_a == a && ref_b == b) return 0;
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return f3[2] ? 3 : 2;
  endfunction

  task automatic model_commit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int path);
    if (path >= 2) begin
      ref_vld = 1'b1; ref_f3 = f3; ref_a = a; ref_b = b;
    end
  endtask

  function automatic logic [2:0] mulop_f3(input logic [MUL_OP_WIDTH-1:0] op);
    case (op)
      MUL_OP_MULH:   return 3'b001;
      MUL_OP_MULHSU: return 3'b010;
      MUL_OP_MULHU:  return 3'b011;
      default:       return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] divop_f3(input logic [DIV_OP_WIDTH-1:0] op);
    case (op)
      DIV_OP_DIVU: return 3'b101;
      DIV_OP_REM:  return 3'b110;
      DIV_OP_REMU: return 3'b111;
      default:     return 3'b100;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_ready <= 1'b0; mul_result <= 32'h0; mul_cnt <= 0; mul_hcnt <= 0;
    end else if (!mul_ready) begin
      mul_hcnt <= 0;
      if (mul_valid) begin
        if (mul_cnt >= mul_lat) begin
          mul_ready <= 1'b1; mul_result <= rv32m(mulop_f3(MULop), mul_a, mul_b); mul_cnt <= 0;
        end else mul_cnt <= mul_cnt + 1;
      end
    end else if (!mul_valid) begin
      if (mul_hcnt >= mul_hold) mul_ready <= 1'b0;
      else mul_hcnt <= mul_hcnt + 1;
    end
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_ready <= 1'b0; div_result <= 32'h0; div_cnt <= 0; div_hcnt <= 0;
    end else if (!div_ready) begin
      div_hcnt <= 0;
      if (div_valid) begin
        if (div_cnt >= div_lat) begin
          div_ready <= 1'b1; div_result <= rv32m(divop_f3(DIVop), div_a, div_b); div_cnt <= 0;
        end else div_cnt <= div_cnt + 1;
      end
    end else if (!div_valid) begin
      if (div_hcnt >= div_hold) div_ready <= 1'b0;
      else div_hcnt <= div_hcnt + 1;
    end
  end

  always @(posedge clk) begin
    mul_prev <= mul_valid;
    div_prev <= div_valid;
    if (mul_valid && !mul_prev) mul_launches <= mul_launches + 1;
    if (div_valid && !div_prev) div_launches <= div_launches + 1;
    if (mul_valid && div_valid) both_cnt <= both_cnt + 1;
  end

  task automatic run_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int nmul, output int ndiv,
                         output logic viol, output logic fell);
    int m0, d0;
    m0 = mul_launches; d0 = div_launches;
    funct3 = f3; op_a = a; op_b = b; valid_i = 1'b1;
    lat = 0; viol = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (ready_o && (mul_ready || div_ready)) viol = 1'b1;
    end while (!ready_o && lat < 300);
    res = result;
    valid_i = 1'b0;
    op_a = $urandom; op_b = $urandom;
    @(posedge clk); #1;
    fell = !ready_o;
    nmul = mul_launches - m0;
    ndiv = div_launches - d0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ready_o, mul_valid, div_valid} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {ready_o, mul_valid, div_valid});
    else n_pass++;
    n_checks++;
    if (result !== 32'h0) $display("FAIL reset_result: got %h expected 0", result);
    else n_pass++;
    n_checks++;
    if ({mul_a, mul_b, div_a, div_b, MULop, DIVop} !== '0) $display("FAIL reset_operands: got nonzero expected 0");
    else n_pass++;
    resetn = 1'b1;
    ref_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] res; int lat, nm, nd; logic viol, fell;
    mul_lat = 2; mul_hold = 0;
    run_req(MDU_F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, nm, nd, viol, fell);
    model_commit(MDU_F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    n_checks++;
    if (res !== 32'h0) $display("FAIL mulh_result: got %h expected 00000000", res); else n_pass++;
    n_checks++;
    if (nm !== 1 || nd !== 0) $display("FAIL mulh_launch: got mul=%0d div=%0d expected 1/0", nm, nd); else n_pass++;
    n_checks++;
    if (lat !== 7) $display("FAIL mulh_latency: got %0d expected 7", lat); else n_pass++;
    run_req(MDU_F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, nm, nd, viol, fell);
    model_commit(MDU_F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    n_checks++;
    if (res !== 32'h1 || nm !== 1) $display("FAIL mul_result: got %h launches %0d expected 00000001 launches 1", res, nm); else n_pass++;
  endtask

  task automatic test_div_zero();
    logic [31:0] res; int lat, nm, nd; logic viol, fell;
    run_req(MDU_F3_DIVU, 32'd100, 32'd0, res, lat, nm, nd, viol, fell);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) $display("FAIL divu_zero_result: got %h expected ffffffff", res); else n_pass++;
    n_checks++;
    if (lat !== 1 || nd !== 0 || nm !== 0) $display("FAIL divu_zero_bypass: got lat=%0d div=%0d expected lat=1 div=0", lat, nd); else n_pass++;
    run_req(MDU_F3_REMU, 32'd100, 32'd0, res, lat, nm, nd, viol, fell);
    n_checks++;
    if (res !== 32'd100 || lat !== 1) $display("FAIL remu_zero: got %h lat %0d expected 00000064 lat 1", res, lat); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [31:0] res; int lat, nm, nd; logic viol, fell;
    run_req(MDU_F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, nm, nd, viol, fell);
    n_checks++;
    if (res !== 32'h8000_0000 || nd !== 0) $display("FAIL div_overflow: got %h div=%0d expected 80000000 div=0", res, nd); else n_pass++;
    run_req(MDU_F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, nm, nd, viol, fell);
    n_checks++;
    if (res !== 32'h0 || nd !== 0 || lat !== 1) $display("FAIL rem_overflow: got %h div=%0d lat=%0d expected 0 div=0 lat=1", res, nd, lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; int lat, nm, nd; logic viol, fell;
    div_lat = 1; div_hold = 0;
    run_req(MDU_F3_DIV, 32'd7, 32'hFFFF_FFFE, res, lat, nm, nd, viol, fell);
    model_commit(MDU_F3_DIV, 32'd7, 32'hFFFF_FFFE, 3);
    n_checks++;
    if (res !== 32'hFFFF_FFFD || nd !== 1 || lat !== 6) $display("FAIL div_unit: got %h div=%0d lat=%0d expected fffffffd div=1 lat=6", res, nd, lat); else n_pass++;
    n_checks++;
    if (fell !== 1'b1) $display("FAIL ready_fall: got ready still high expected low"); else n_pass++;
    run_req(MDU_F3_DIV, 32'd7, 32'hFFFF_FFFE, res, lat, nm, nd, viol, fell);
    n_checks++;
    if (res !== 32'hFFFF_FFFD || nd !== 0 || lat !== 1) $display("FAIL div_cache_hit: got %h div=%0d lat=%0d expected fffffffd div=0 lat=1", res, nd, lat); else n_pass++;
  endtask

  task automatic test_release_hold();
    logic [31:0] res; int lat, nm, nd; logic viol, fell;
    div_lat = 0; div_hold = 2;
    run_req(MDU_F3_DIVU, 32'd1000, 32'd7, res, lat, nm, nd, viol, fell);
    model_commit(MDU_F3_DIVU, 32'd1000, 32'd7, 3);
    n_checks++;
    if (res !== 32'd142 || lat !== 7) $display("FAIL release_hold: got %h lat=%0d expected 0000008e lat=7", res, lat); else n_pass++;
    n_checks++;
    if (viol !== 1'b0) $display("FAIL release_ready_overlap: got ready_o with unit ready expected none"); else n_pass++;
    div_hold = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int lat, nm, nd; logic viol, fell;
    mul_lat = 0; mul_hold = 0;
    run_req(MDU_F3_MUL, 32'd3, 32'd5, res, lat, nm, nd, viol, fell);
    model_commit(MDU_F3_MUL, 32'd3, 32'd5, 2);
    mul_lat = 20;
    funct3 = MDU_F3_MUL; op_a = 32'd6; op_b = 32'd7; valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (mul_valid !== 1'b1) $display("FAIL midop_launch: got mul_valid=%b expected 1", mul_valid); else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({ready_o, mul_valid, div_valid} !== 3'b000 || result !== 32'h0 || {mul_a, mul_b, MULop} !== '0)
      $display("FAIL async_reset: got flags=%b result=%h expected 000/00000000", {ready_o, mul_valid, div_valid}, result);
    else n_pass++;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    ref_vld = 1'b0;
    mul_lat = 0;
    @(posedge clk); #1;
    run_req(MDU_F3_MUL, 32'd3, 32'd5, res, lat, nm, nd, viol, fell);
    model_commit(MDU_F3_MUL, 32'd3, 32'd5, 2);
    n_checks++;
    if (res !== 32'd15 || nm !== 1 || lat !== 5) $display("FAIL post_reset_miss: got %h mul=%0d lat=%0d expected 0000000f mul=1 lat=5", res, nm, lat); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, exp_res; logic [2:0] f3; int lat, nm, nd, path, exp_lat; logic viol, fell;
    f3 = 3'h0; a = 32'h0; b = 32'h0;
    for (int i = 0; i < 80; i++) begin
      if (i == 0 || $urandom_range(3) != 0) begin
        f3 = 3'($urandom_range(7));
        a = ($urandom_range(1) == 1) ? pool[$urandom_range(5)] : $urandom;
        b = ($urandom_range(1) == 1) ? pool[$urandom_range(5)] : $urandom;
      end
      mul_lat = $urandom_range(3); mul_hold = $urandom_range(3);
      div_lat = $urandom_range(3); div_hold = $urandom_range(3);
      path = predict(f3, a, b);
      exp_res = rv32m(f3, a, b);
      exp_lat = (path < 2) ? 1 : 5 + ((path == 2) ? mul_lat + mul_hold : div_lat + div_hold);
      run_req(f3, a, b, res, lat, nm, nd, viol, fell);
      model_commit(f3, a, b, path);
      n_checks++;
      if (res !== exp_res) $display("FAIL rand_result[%0d] f3=%0d a=%h b=%h: got %h expected %h", i, f3, a, b, res, exp_res); else n_pass++;
      n_checks++;
      if (lat !== exp_lat) $display("FAIL rand_latency[%0d] path=%0d: got %0d expected %0d", i, path, lat, exp_lat); else n_pass++;
      n_checks++;
      if (nm !== ((path == 2) ? 1 : 0) || nd !== ((path == 3) ? 1 : 0))
        $display("FAIL rand_launch[%0d] path=%0d: got mul=%0d div=%0d", i, path, nm, nd);
      else n_pass++;
      n_checks++;
      if (fell !== 1'b1 || viol !== 1'b0) $display("FAIL rand_handshake[%0d]: got fell=%b overlap=%b expected 1/0", i, fell, viol); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_release_hold();
    test_reset_mid();
    test_random();
    n_checks++;
    if (both_cnt !== 0) $display("FAIL valid_exclusive: got %0d overlapping cycles expected 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
